// File: rtl/sad_acc.sv
// Block accumulator for the SAD result stream: sums, maxes and counts up to N
// samples per block and presents each closed block on a registered vld/rdy output.
module sad_acc #(
    parameter int W  = 8,
    parameter int N  = 16,
    parameter int CW = W + 2 + $clog2(N),
    parameter int NW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vld_up,
    input  logic [W+1:0]  din,
    input  logic          last_up,
    output logic          acc_rdy,
    output logic          acc_vld,
    output logic [CW-1:0] acc_sum,
    output logic [W+1:0]  acc_max,
    output logic [NW-1:0] acc_cnt,
    input  logic          rdy_dn
);

    localparam logic [NW-1:0] CNT_LAST = NW'(N - 1);

    logic [CW-1:0] run_sum;
    logic [W+1:0]  run_max;
    logic [NW-1:0] run_cnt;

    logic          closing_sample;
    logic          take;
    logic          close;
    logic [CW-1:0] sum_next;
    logic [W+1:0]  max_next;
    logic [NW-1:0] cnt_next;

    assign closing_sample = (run_cnt == CNT_LAST) | last_up;
    // Only a closing sample needs the output register; others always go through.
    assign acc_rdy  = ~acc_vld | rdy_dn | ~closing_sample;
    assign take     = vld_up & acc_rdy;
    assign close    = take & closing_sample;
    assign sum_next = run_sum + CW'(din);
    assign max_next = (din > run_max) ? din : run_max;
    assign cnt_next = run_cnt + NW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_sum <= '0;
            run_max <= '0;
            run_cnt <= '0;
        end else if (take) begin
            if (close) begin
                run_sum <= '0;
                run_max <= '0;
                run_cnt <= '0;
            end else begin
                run_sum <= sum_next;
                run_max <= max_next;
                run_cnt <= cnt_next;
            end
        end
    end

    // A close while the register is stalled cannot occur: acc_rdy blocks it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_vld <= 1'b0;
            acc_sum <= '0;
            acc_max <= '0;
            acc_cnt <= '0;
        end else if (close) begin
            acc_vld <= 1'b1;
            acc_sum <= sum_next;
            acc_max <= max_next;
            acc_cnt <= cnt_next;
        end else if (acc_vld && rdy_dn) begin
            acc_vld <= 1'b0;
        end
    end

endmodule
